// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the control unit and the shared
// multiply/divide engine.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Shared multicycle multiply/divide engine with HI/LO result registers.
// One shift-add or restoring-divide step per RUN cycle, sign fix-up in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic               fix_phase_reg;
  logic               is_div_reg;
  logic               neg_lo_reg;
  logic               neg_hi_reg;
  logic               dz_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [2*WIDTH-1:0] acc_reg;

  logic               start_go;
  logic               div_by_zero;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   hi_part, lo_part;
  logic [2*WIDTH-1:0] mul_step, div_step, fix_val;

  // Operand conditioning: signed ops (op[0]==0) work on magnitudes.
  always_comb begin
    start_go    = (state_reg == S_IDLE) && bus.start && !bus.flush;
    div_by_zero = bus.op[1] && (bus.b == '0);
    a_neg       = !bus.op[0] && bus.a[WIDTH-1];
    b_neg       = !bus.op[0] && bus.b[WIDTH-1];
    a_mag       = a_neg ? -bus.a : bus.a;
    b_mag       = b_neg ? -bus.b : bus.b;
  end

  // acc holds {partial product high, multiplier} for MULT and
  // {partial remainder, dividend/quotient} for DIV.
  always_comb begin
    hi_part   = acc_reg[2*WIDTH-1:WIDTH];
    lo_part   = acc_reg[WIDTH-1:0];
    mul_sum   = {1'b0, hi_part} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_step  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {hi_part, acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    if (is_div_reg) begin
      fix_val = {(neg_hi_reg ? -hi_part : hi_part), (neg_lo_reg ? -lo_part : lo_part)};
    end else begin
      fix_val = neg_lo_reg ? -acc_reg : acc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (bus.start) state_next = div_by_zero ? S_DONE : S_RUN;
        S_RUN:  if (cnt_reg == '0) state_next = S_FIX;
        S_FIX:  if (fix_phase_reg) state_next = S_DONE;
        S_DONE: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      fix_phase_reg <= 1'b0;
      is_div_reg    <= 1'b0;
      neg_lo_reg    <= 1'b0;
      neg_hi_reg    <= 1'b0;
      dz_reg        <= 1'b0;
      opnd_reg      <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      acc_reg       <= '0;
    end else if (!bus.flush) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.hi_we) hi_reg <= bus.wdata;
          if (bus.lo_we) lo_reg <= bus.wdata;
          if (start_go) begin
            is_div_reg    <= bus.op[1];
            dz_reg        <= div_by_zero;
            neg_lo_reg    <= a_neg ^ b_neg;
            neg_hi_reg    <= bus.op[1] ? a_neg : (a_neg ^ b_neg);
            opnd_reg      <= bus.op[1] ? b_mag : a_mag;
            acc_reg       <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            cnt_reg       <= CW'(WIDTH - 1);
            fix_phase_reg <= 1'b0;
          end
        end
        S_RUN: begin
          acc_reg <= is_div_reg ? div_step : mul_step;
          cnt_reg <= cnt_reg - CW'(1);
        end
        S_FIX: begin
          // First FIX cycle applies the signs, second commits to HI/LO.
          if (!fix_phase_reg) begin
            acc_reg       <= fix_val;
            fix_phase_reg <= 1'b1;
          end else begin
            hi_reg <= hi_part;
            lo_reg <= lo_part;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.done     = (state_reg == S_DONE) && !bus.flush;
  assign bus.div_zero = bus.done && dz_reg;
endmodule
